// File: rtl/demux_mto2m.sv
// Row-serial board loader: collects N rows of N W-bit tiles into a shadow buffer,
// then commits the whole board atomically into bank 0 or bank 1.
module demux_mto2m #(
    parameter int W = 12,
    parameter int N = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [N-1:0][W-1:0]           in_row_i,
    input  logic                          s_i,
    input  logic                          abort_i,
    output logic [N-1:0][N-1:0][W-1:0]    m0_o,
    output logic [N-1:0][N-1:0][W-1:0]    m1_o,
    output logic                          done0_o,
    output logic                          done1_o,
    output logic                          busy_o
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 row_cnt_q, row_cnt_d;
    logic                          bank_q, bank_d;
    logic                          done0_q, done0_d;
    logic                          done1_q, done1_d;
    logic                          commit;
    logic                          accept;
    logic [N-1:0][W-1:0]           shadow_q [N];
    logic [N-1:0][N-1:0][W-1:0]    m0_q, m1_q;

    assign in_ready_o = (state_q != COMMIT);
    // abort outranks in_valid, so a beat presented alongside it is dropped
    assign accept     = in_valid_i && in_ready_o && !abort_i;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        bank_d    = bank_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        commit    = 1'b0;
        if (abort_i) begin
            state_d   = IDLE;
            row_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bank_d    = s_i;
                        row_cnt_d = CW'(1);
                        state_d   = LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        row_cnt_d = row_cnt_q + 1'b1;
                        if (row_cnt_q == CW'(N - 1)) begin
                            state_d = COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    commit    = 1'b1;
                    done0_d   = !bank_q;
                    done1_d   = bank_q;
                    row_cnt_d = '0;
                    state_d   = IDLE;
                end
                default: begin
                    state_d   = IDLE;
                    row_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            bank_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            bank_q    <= bank_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
        end
    end

    // row_cnt_q is zero in IDLE, so the first beat lands in row 0 too
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q[gi] <= '0;
                end else if (accept && (row_cnt_q == CW'(gi))) begin
                    shadow_q[gi] <= in_row_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_q <= '0;
            m1_q <= '0;
        end else if (commit) begin
            for (int r = 0; r < N; r++) begin
                if (bank_q) begin
                    m1_q[r] <= shadow_q[r];
                end else begin
                    m0_q[r] <= shadow_q[r];
                end
            end
        end
    end

    assign m0_o    = m0_q;
    assign m1_o    = m1_q;
    assign done0_o = done0_q;
    assign done1_o = done1_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_demux_mto2m.sv
// Bench for demux_mto2m: directed board loads plus random traffic, each cycle compared
// against a queue-based model of "collect N rows, then publish the board".
module tb_demux_mto2m;
    localparam int W  = 12;
    localparam int N  = 4;
    localparam int BW = N * N * W;

    typedef logic [N-1:0][W-1:0]        row_t;
    typedef logic [N-1:0][N-1:0][W-1:0] board_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   in_valid_i;
    logic   in_ready_o;
    row_t   in_row_i;
    logic   s_i;
    logic   abort_i;
    board_t m0_o, m1_o;
    logic   done0_o, done1_o, busy_o;

    demux_mto2m #(.W(W), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_row_i   (in_row_i),
        .s_i        (s_i),
        .abort_i    (abort_i),
        .m0_o       (m0_o),
        .m1_o       (m1_o),
        .done0_o    (done0_o),
        .done1_o    (done1_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: rows gathered so far, target bank, and a pending publish step
    row_t   rows_q[$];
    logic   tgt_bank;
    logic   pend_commit;
    board_t em0, em1;
    logic   edone0, edone1;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        rows_q.delete();
        tgt_bank    = 1'b0;
        pend_commit = 1'b0;
        em0         = '0;
        em1         = '0;
        edone0      = 1'b0;
        edone1      = 1'b0;
    endtask

    task automatic model_step(input logic v, input row_t row, input logic s, input logic ab);
        edone0 = 1'b0;
        edone1 = 1'b0;
        if (ab) begin
            rows_q.delete();
            pend_commit = 1'b0;
        end else if (pend_commit) begin
            for (int r = 0; r < N; r++) begin
                if (tgt_bank) em1[r] = rows_q[r];
                else          em0[r] = rows_q[r];
            end
            if (tgt_bank) edone1 = 1'b1;
            else          edone0 = 1'b1;
            rows_q.delete();
            pend_commit = 1'b0;
        end else if (v) begin
            if (rows_q.size() == 0) tgt_bank = s;
            rows_q.push_back(row);
            if (rows_q.size() == N) pend_commit = 1'b1;
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_m0"},    m0_o,       em0);
        chk({pfx, "_m1"},    m1_o,       em1);
        chk({pfx, "_done0"}, done0_o,    edone0);
        chk({pfx, "_done1"}, done1_o,    edone1);
        chk({pfx, "_ready"}, in_ready_o, !pend_commit);
        chk({pfx, "_busy"},  busy_o,     (pend_commit || rows_q.size() != 0));
    endtask

    // Called just after a falling edge: drive, clock, update model, compare
    task automatic cycle(input string pfx, input logic v, input row_t row,
                         input logic s, input logic ab);
        in_valid_i = v;
        in_row_i   = row;
        s_i        = s;
        abort_i    = ab;
        @(posedge clk);
        model_step(v, row, s, ab);
        @(negedge clk);
        check_all(pfx);
    endtask

    function automatic row_t mkrow(input int base);
        row_t r;
        for (int c = 0; c < N; c++) r[c] = W'(base + c);
        return r;
    endfunction

    function automatic row_t fill_row(input int val);
        row_t r;
        for (int c = 0; c < N; c++) r[c] = W'(val);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int c = 0; c < N; c++) r[c] = W'($urandom);
        return r;
    endfunction

    initial begin
        board_t all7;
        for (int r = 0; r < N; r++) all7[r] = fill_row(7);

        // 1. reset
        rst_n      = 1'b0;
        in_valid_i = 1'b0;
        in_row_i   = '0;
        s_i        = 1'b0;
        abort_i    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;

        // 2. bank 1, back-to-back
        for (int r = 0; r < N; r++) cycle("t2", 1'b1, mkrow(100 + 10 * r), 1'b1, 1'b0);
        cycle("t2c", 1'b0, '0, 1'b0, 1'b0);
        chk("t2_done1", done1_o, 1'b1);
        chk("t2_m1_33", m1_o[3][3], 133);
        chk("t2_m1_00", m1_o[0][0], 100);
        chk("t2_m0",    m0_o, '0);
        cycle("t2h", 1'b0, '0, 1'b0, 1'b0);
        chk("t2_done1_off", done1_o, 1'b0);

        // 3. bank 0 with stalls, S toggled mid-load
        for (int r = 0; r < N; r++) begin
            cycle("t3", 1'b1, mkrow(200 + 10 * r), (r >= 2), 1'b0);
            if (r < N - 1) cycle("t3s", 1'b0, rand_row(), 1'b1, 1'b0);
        end
        cycle("t3c", 1'b0, '0, 1'b1, 1'b0);
        chk("t3_done0",  done0_o, 1'b1);
        chk("t3_done1",  done1_o, 1'b0);
        chk("t3_m0_21",  m0_o[2][1], 221);
        chk("t3_m1_33",  m1_o[3][3], 133);

        // 4. abort after two rows of 5s, then a full board of 7s
        cycle("t4", 1'b1, fill_row(5), 1'b0, 1'b0);
        cycle("t4", 1'b1, fill_row(5), 1'b0, 1'b0);
        cycle("t4a", 1'b1, fill_row(5), 1'b0, 1'b1);
        chk("t4_busy_after_abort", busy_o, 1'b0);
        for (int r = 0; r < N; r++) cycle("t4", 1'b1, fill_row(7), 1'b0, 1'b0);
        cycle("t4c", 1'b0, '0, 1'b0, 1'b0);
        chk("t4_m0_all7", m0_o, all7);

        // 5. in_valid held through COMMIT
        for (int r = 0; r < N; r++) cycle("t5", 1'b1, mkrow(300 + 10 * r), 1'b1, 1'b0);
        chk("t5_ready_commit", in_ready_o, 1'b0);
        cycle("t5c", 1'b1, mkrow(400), 1'b0, 1'b0);
        cycle("t5", 1'b1, mkrow(400), 1'b0, 1'b0);
        chk("t5_busy_row0", busy_o, 1'b1);
        for (int r = 1; r < N; r++) cycle("t5", 1'b1, mkrow(400 + 10 * r), 1'b1, 1'b0);
        cycle("t5c2", 1'b0, '0, 1'b0, 1'b0);
        chk("t5_m0_33", m0_o[3][3], 433);

        // 6. async reset mid-load, no clock edge needed
        for (int r = 0; r < N - 1; r++) cycle("t6", 1'b1, rand_row(), 1'b1, 1'b0);
        in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("t6_idle", 1'b0, '0, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", ($urandom_range(0, 9) < 7), rand_row(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
